generate_2x2_window: RTL



---
 rtl/generate_2x2_window.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/generate_2x2_window.sv
// 2x2 window generator: one line buffer plus a two-stage pipeline; emits p11..p22 with frame edge flags.
// Define EDGE_REPLICATE_EN to replicate out-of-frame neighbours instead of zero-filling them.
module generate_2x2_window #(
    parameter int          DATA_WIDTH = 8,
    parameter logic [10:0] H_DISP     = 11'd1280,
    parameter logic [10:0] V_DISP     = 11'd720
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pre_img_vsync,
    input  logic                  pre_img_hsync,
    input  logic                  pre_img_valid,
    input  logic [DATA_WIDTH-1:0] pre_img_data,
    output logic                  matrix_img_vsync,
    output logic                  matrix_img_hsync,
    output logic                  matrix_img_valid,
    output logic                  matrix_top_edge_flag,
    output logic                  matrix_bottom_edge_flag,
    output logic                  matrix_left_edge_flag,
    output logic                  matrix_right_edge_flag,
    output logic [DATA_WIDTH-1:0] matrix_p11,
    output logic [DATA_WIDTH-1:0] matrix_p12,
    output logic [DATA_WIDTH-1:0] matrix_p21,
    output logic [DATA_WIDTH-1:0] matrix_p22
);

    localparam int COL_W = (H_DISP > 11'd1) ? $clog2(H_DISP) : 1;
    localparam int ROW_W = (V_DISP > 11'd1) ? $clog2(V_DISP) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_DISP - 11'd1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_DISP - 11'd1);

    logic                  r_vsync_prev;
    logic [COL_W-1:0]      r_col_cnt;
    logic [ROW_W-1:0]      r_row_cnt;
    logic                  w_vsync_rise;

    logic [DATA_WIDTH-1:0] r_line_buf [0:H_DISP-1];
    logic [DATA_WIDTH-1:0] r_lb_q;

    logic                  r_vsync_s1, r_hsync_s1, r_valid_s1;
    logic [DATA_WIDTH-1:0] r_d1;
    logic                  r_top_s1, r_bottom_s1, r_left_s1, r_right_s1;

    logic                  r_vsync_s2, r_hsync_s2, r_valid_s2;
    logic                  r_top_s2, r_bottom_s2, r_left_s2, r_right_s2;
    logic [DATA_WIDTH-1:0] r_p11, r_p12, r_p21, r_p22;
    logic [DATA_WIDTH-1:0] w_p11, w_p12, w_p21, w_p22;

    assign w_vsync_rise = pre_img_vsync & ~r_vsync_prev;

    // A vsync rising edge restarts the frame position and outranks a coincident pixel count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync_prev <= 1'b0;
            r_col_cnt    <= '0;
            r_row_cnt    <= '0;
        end else begin
            r_vsync_prev <= pre_img_vsync;
            if (w_vsync_rise) begin
                r_col_cnt <= '0;
                r_row_cnt <= '0;
            end else if (pre_img_valid) begin
                if (r_col_cnt == COL_LAST) begin
                    r_col_cnt <= '0;
                    r_row_cnt <= (r_row_cnt == ROW_LAST) ? '0 : r_row_cnt + 1'b1;
                end else begin
                    r_col_cnt <= r_col_cnt + 1'b1;
                end
            end
        end
    end

    // Read-before-write: lb_q receives the previous row's pixel at this column.
    always_ff @(posedge clk) begin
        if (!rst && pre_img_valid) begin
            r_lb_q                 <= r_line_buf[r_col_cnt];
            r_line_buf[r_col_cnt]  <= pre_img_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync_s1  <= 1'b0;
            r_hsync_s1  <= 1'b0;
            r_valid_s1  <= 1'b0;
            r_d1        <= '0;
            r_top_s1    <= 1'b0;
            r_bottom_s1 <= 1'b0;
            r_left_s1   <= 1'b0;
            r_right_s1  <= 1'b0;
        end else begin
            r_vsync_s1 <= pre_img_vsync;
            r_hsync_s1 <= pre_img_hsync;
            r_valid_s1 <= pre_img_valid;
            if (pre_img_valid) begin
                r_d1        <= pre_img_data;
                r_top_s1    <= (r_row_cnt == '0);
                r_bottom_s1 <= (r_row_cnt == ROW_LAST);
                r_left_s1   <= (r_col_cnt == '0);
                r_right_s1  <= (r_col_cnt == COL_LAST);
            end
        end
    end

    // Shift the window one column and patch neighbours that fall outside the frame.
    always_comb begin
        w_p22 = r_d1;
        w_p21 = r_p22;
        w_p12 = r_lb_q;
        w_p11 = r_p12;
`ifdef EDGE_REPLICATE_EN
        if (r_left_s1) begin
            w_p21 = w_p22;
            w_p11 = w_p12;
        end
        if (r_top_s1) begin
            w_p11 = w_p21;
            w_p12 = w_p22;
        end
`else
        if (r_left_s1) begin
            w_p21 = '0;
            w_p11 = '0;
        end
        if (r_top_s1) begin
            w_p12 = '0;
            w_p11 = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync_s2  <= 1'b0;
            r_hsync_s2  <= 1'b0;
            r_valid_s2  <= 1'b0;
            r_top_s2    <= 1'b0;
            r_bottom_s2 <= 1'b0;
            r_left_s2   <= 1'b0;
            r_right_s2  <= 1'b0;
            r_p11       <= '0;
            r_p12       <= '0;
            r_p21       <= '0;
            r_p22       <= '0;
        end else begin
            r_vsync_s2 <= r_vsync_s1;
            r_hsync_s2 <= r_hsync_s1;
            r_valid_s2 <= r_valid_s1;
            if (r_valid_s1) begin
                r_top_s2    <= r_top_s1;
                r_bottom_s2 <= r_bottom_s1;
                r_left_s2   <= r_left_s1;
                r_right_s2  <= r_right_s1;
                r_p11       <= w_p11;
                r_p12       <= w_p12;
                r_p21       <= w_p21;
                r_p22       <= w_p22;
            end
        end
    end

    assign matrix_img_vsync        = r_vsync_s2;
    assign matrix_img_hsync        = r_hsync_s2;
    assign matrix_img_valid        = r_valid_s2;
    assign matrix_top_edge_flag    = r_top_s2;
    assign matrix_bottom_edge_flag = r_bottom_s2;
    assign matrix_left_edge_flag   = r_left_s2;
    assign matrix_right_edge_flag  = r_right_s2;
    assign matrix_p11              = r_p11;
    assign matrix_p12              = r_p12;
    assign matrix_p21              = r_p21;
    assign matrix_p22              = r_p22;

endmodule
